rca_result_display: RTL and testbench

- Consumer end of the 4-bit ripple-carry adder result interface.
- Accepts {carry, sum} over a valid/ready handshake and converts the 5-bit value to two BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed 4-digit common-anode 7-segment display: decimal on digits 1..0, raw hex on digits 3..2.

---
 rtl/rca_result_display.sv | 163 ++++++++++++++++
 tb/tb_rca_result_display.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rca_result_display.sv
// Result display for a 4-bit ripple-carry adder: double-dabble BCD conversion and 4-digit multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit and a zero hex high digit.
module rca_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_sum,
  input  logic       in_carry,
  output logic       in_ready,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state;
  logic [4:0]  value_q;
  logic [4:0]  shift_q;
  logic [7:0]  bcd_q;
  logic [2:0]  iter_q;
  logic [3:0]  disp_ones;
  logic [3:0]  disp_tens;
  logic [3:0]  disp_hex_lo;
  logic [3:0]  disp_hex_hi;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]  digit_idx;
  logic [1:0]  digit_next;
  logic [7:0]  bcd_adj;
  logic [12:0] dd_shift;
  logic [3:0]  digit_val;
  logic        digit_blank;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  // One double-dabble step: correct nibbles >= 5, then shift the whole {bcd, binary} left.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    dd_shift = {bcd_adj, shift_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      value_q     <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      disp_ones   <= '0;
      disp_tens   <= '0;
      disp_hex_lo <= '0;
      disp_hex_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value_q <= {in_carry, in_sum};
            shift_q <= {in_carry, in_sum};
            bcd_q   <= '0;
            iter_q  <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= dd_shift[12:5];
          shift_q <= dd_shift[4:0];
          iter_q  <= iter_q + 3'd1;
          if (iter_q == 3'd4) state <= COMMIT;
        end
        COMMIT: begin
          disp_ones   <= bcd_q[3:0];
          disp_tens   <= bcd_q[7:4];
          disp_hex_lo <= value_q[3:0];
          disp_hex_hi <= {3'b000, value_q[4]};
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digit_next = (refresh_cnt == CNT_MAX) ? digit_idx + 2'd1 : digit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else begin
      refresh_cnt <= (refresh_cnt == CNT_MAX) ? '0 : refresh_cnt + 1'b1;
      digit_idx   <= digit_next;
    end
  end

  always_comb begin
    digit_val   = disp_ones;
    digit_blank = 1'b0;
    case (digit_next)
      2'd0: digit_val = disp_ones;
      2'd1: begin
        digit_val = disp_tens;
`ifdef LEADING_ZERO_BLANK_EN
        digit_blank = (disp_tens == 4'd0);
`else
        digit_blank = 1'b0;
`endif
      end
      2'd2: digit_val = disp_hex_lo;
      default: begin
        digit_val = disp_hex_hi;
`ifdef LEADING_ZERO_BLANK_EN
        digit_blank = (disp_hex_hi == 4'd0);
`else
        digit_blank = 1'b0;
`endif
      end
    endcase
  end

  // Anode, segments and dp are registered from the same index so they switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? 4'b1111 : ~(4'b0001 << digit_next);
      seg <= digit_blank ? 7'b1111111 : seg_code(digit_val);
      dp  <= (digit_next != 2'd2);
    end
  end

endmodule

// File: tb/tb_rca_result_display.sv
// Self-checking bench for rca_result_display with REFRESH_DIV=2 and a value-level reference model.
module tb_rca_result_display;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_sum = '0;
  logic       in_carry = 1'b0;
  logic       in_ready;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int shown_v = 0;

  rca_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry),
    .in_ready(in_ready), .blank(blank), .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released; the digit being lit follows from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;  2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;  4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;  8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000; 10: seg_of = 7'b0001000; 11: seg_of = 7'b0000011;
      12: seg_of = 7'b1000110; 13: seg_of = 7'b0100001; 14: seg_of = 7'b0000110;
      15: seg_of = 7'b0001110;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] expected_seg(input int idx, input int v);
    int d;
    case (idx)
      0: d = v % 10;
      1: d = v / 10;
      2: d = v % 16;
      default: d = v / 16;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == 1 || idx == 3) && d == 0) d = -1;
`endif
    expected_seg = seg_of(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int idx;
    logic [3:0] exp_an;
    idx = (cyc / DIV) % 4;
    exp_an = blank ? 4'b1111 : ~(4'b0001 << idx);
    check({tag, ".an"}, 32'(an), 32'(exp_an));
    if (!blank) begin
      check({tag, ".seg"}, 32'(seg), 32'(expected_seg(idx, shown_v)));
      check({tag, ".dp"}, 32'(dp), (idx == 2) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic scanCheck(input string tag);
    for (int i = 0; i < 4 * DIV; i++) begin
      checkOutput(tag);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] v, input string tag);
    int lowc;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    check({tag, ".ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sum   = v[3:0];
    in_carry = v[4];
    @(negedge clk);
    in_valid = 1'b0;
    lowc = 0;
    while (!in_ready && lowc < 20) begin
      lowc++;
      check({tag, ".busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    check({tag, ".latency"}, 32'(lowc), 32'd6);
    shown_v = int'(v);
    @(negedge clk);
    scanCheck(tag);
  endtask

  initial begin
    logic [4:0] rv;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.ready", 32'(in_ready), 32'd1);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.an", 32'(an), 32'b1110);
    check("reset.seg", 32'(seg), 32'(expected_seg(0, 0)));
    check("reset.dp", 32'(dp), 32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("reset_scan");
      @(negedge clk);
    end

    applyStimulus(5'd8, "sum8");
    applyStimulus(5'd17, "sum17");
    applyStimulus(5'd31, "sum31");

    for (int i = 0; i < 6; i++) begin
      rv = 5'($urandom_range(0, 31));
      applyStimulus(rv, "random");
    end

    // A request while busy must be dropped, not queued.
    in_valid = 1'b1; in_sum = 4'd9; in_carry = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sum = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    shown_v = 9;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("ignored.busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    scanCheck("ignored");

    // Reset two cycles into a conversion throws the value away.
    in_valid = 1'b1; in_sum = 4'd4; in_carry = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset.busy", 32'(busy), 32'd0);
    check("midreset.ready", 32'(in_ready), 32'd1);
    check("midreset.an", 32'(an), 32'b1110);
    check("midreset.seg", 32'(seg), 32'(expected_seg(0, 0)));
    @(negedge clk);
    rst = 1'b0;
    shown_v = 0;
    scanCheck("after_reset");

    applyStimulus(5'd23, "sum23");

    blank = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("blank.an", 32'(an), 32'b1111);
      @(negedge clk);
    end
    blank = 1'b0;
    @(negedge clk);
    scanCheck("unblank");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
